// File: rtl/boa_mem_pkg.sv
// Shared types for the boa32 memory fabric: request payload, arbiter states
// and the arbiter port limit.
package boa_mem_pkg;

  localparam int unsigned BOA_MEM_ARB_MAX_PORTS = 8;
  localparam int unsigned BOA_MEM_DW            = 32;
  localparam int unsigned BOA_MEM_AW            = 30;
  localparam int unsigned BOA_MEM_BEW           = 4;

  typedef struct packed {
    logic                   re;
    logic [BOA_MEM_BEW-1:0] we;
    logic [31:2]            addr;
    logic [BOA_MEM_DW-1:0]  wdata;
  } boa_mem_req_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } boa_arb_state_t;

  // A port is requesting when it reads or writes any byte lane.
  function automatic logic is_request(input boa_mem_req_t r);
    return r.re | (|r.we);
  endfunction

endpackage

// File: rtl/boa_rr_select.sv
// Rotating-priority encoder: picks the first set request at or after ptr,
// wrapping to index 0, and returns it as one-hot and as an index.
module boa_rr_select #(
  parameter int unsigned n = 2,
  parameter int unsigned w = 1
) (
  input  logic [n-1:0] req,
  input  logic [w-1:0] ptr,
  output logic [n-1:0] grant,
  output logic [w-1:0] idx,
  output logic         any
);

  logic         hi_any;
  logic [w-1:0] hi_idx;
  logic         lo_any;
  logic [w-1:0] lo_idx;

  // Two scans: indices at/after the pointer first, then the wrapped tail.
  always_comb begin
    hi_any = 1'b0;
    hi_idx = '0;
    lo_any = 1'b0;
    lo_idx = '0;
    for (int i = 0; i < int'(n); i++) begin
      if (!hi_any && req[i] && (w'(i) >= ptr)) begin
        hi_any = 1'b1;
        hi_idx = w'(i);
      end
      if (!lo_any && req[i]) begin
        lo_any = 1'b1;
        lo_idx = w'(i);
      end
    end
  end

  always_comb begin
    any   = hi_any | lo_any;
    idx   = hi_any ? hi_idx : lo_idx;
    grant = '0;
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/boa_mem_arbiter.sv
// Shares one downstream memory port between several boa32 bus masters with a
// zero-latency grant in IDLE and a lock held until the owner's mem_ready.
module boa_mem_arbiter #(
  parameter int unsigned ports       = 2,
  parameter int unsigned round_robin = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ports-1:0]           req_re,
  input  logic [ports-1:0][3:0]      req_we,
  input  logic [ports-1:0][31:2]     req_addr,
  input  logic [ports-1:0][31:0]     req_wdata,
  output logic [ports-1:0]           req_ready,
  output logic [31:0]                req_rdata,
  output logic                       mem_re,
  output logic [3:0]                 mem_we,
  output logic [31:2]                mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic                       mem_ready,
  input  logic [31:0]                mem_rdata,
  output logic                       busy,
  output logic [$clog2(ports)-1:0]   grant_id
);

  import boa_mem_pkg::*;

  localparam int unsigned IW = $clog2(ports);

  boa_arb_state_t state;
  logic [IW-1:0]  ptr;
  logic [IW-1:0]  owner;
  logic [IW-1:0]  last_grant;

  boa_mem_req_t   port_req [ports];
  logic [ports-1:0] req_vec;
  logic [ports-1:0] win_onehot;
  logic [IW-1:0]  win_idx;
  logic           win_any;

  boa_mem_req_t   sel;
  logic [IW-1:0]  sel_idx;
  logic           active;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] i);
    return (i == IW'(ports - 1)) ? '0 : i + IW'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < int'(ports); i++) begin
      port_req[i] = '{re: req_re[i], we: req_we[i], addr: req_addr[i], wdata: req_wdata[i]};
      req_vec[i]  = is_request(port_req[i]);
    end
  end

  boa_rr_select #(
    .n (ports),
    .w (IW)
  ) u_select (
    .req   (req_vec),
    .ptr   (ptr),
    .grant (win_onehot),
    .idx   (win_idx),
    .any   (win_any)
  );

  // The owner is forwarded verbatim while locked, even if it misbehaves.
  always_comb begin
    sel_idx = (state == LOCKED) ? owner : win_idx;
    active  = (state == LOCKED) | win_any;
    sel     = port_req[sel_idx];
  end

  // Reset forces the downstream strobes and all completions low immediately.
  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 4'h0;
    mem_addr  = sel.addr;
    mem_wdata = sel.wdata;
    req_ready = '0;
    req_rdata = mem_rdata;
    busy      = 1'b0;
    grant_id  = last_grant;
    if (rst) begin
      grant_id = '0;
    end else begin
      busy = (state == LOCKED);
      if (active) begin
        grant_id = sel_idx;
        mem_re   = sel.re;
        mem_we   = sel.we;
        if (mem_ready) req_ready[sel_idx] = 1'b1;
      end
    end
  end

  // Arbitration state; the pointer advances past every completing port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      last_grant <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_any) begin
            last_grant <= win_idx;
            if (mem_ready) begin
              if (round_robin != 0) ptr <= next_ptr(win_idx);
            end else begin
              owner <= win_idx;
              state <= LOCKED;
            end
          end
        end
        LOCKED: begin
          if (mem_ready) begin
            state <= IDLE;
            if (round_robin != 0) ptr <= next_ptr(owner);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_onehot;
  assign unused_onehot = ^win_onehot;

endmodule

// File: doc/boa_mem_arbiter.md
Name: boa_mem_arbiter

Overview:
- Shares one downstream memory port between `ports` requesters: the CPU program bus (port 0), the data bus (port 1) and, later, a debug/DMA master.
- Sits between the boa32 CPU bus masters and the single SRAM/peripheral fabric port.
- Zero-latency grant when idle; grant is locked until the transaction completes.
- Round-robin fairness between requesters, so a looping data access can never starve fetch.

Parameters:
- ports, 2, number of requesters (2..8).
- round_robin, 1, 1 = rotating priority; 0 = fixed priority, lowest index wins.

Ports:
- clk  input  1  CPU clock
- rst  input  1  synchronous reset, active-high
- req_re  input  [ports]  requester read strobe
- req_we  input  [ports][3:0]  requester byte write enables
- req_addr  input  [ports][31:2]  requester word address
- req_wdata  input  [ports][31:0]  requester write data
- req_ready  output  [ports]  transaction complete for that requester
- req_rdata  output  32  read data, broadcast; valid for the requester whose req_ready is high
- mem_re  output  1  downstream read strobe
- mem_we  output  4  downstream byte write enables
- mem_addr  output  [31:2]  downstream address
- mem_wdata  output  32  downstream write data
- mem_ready  input  1  downstream completion, same-cycle or later
- mem_rdata  input  32  downstream read data, valid with mem_ready
- busy  output  1  a transaction is locked (state LOCKED)
- grant_id  output  $clog2(ports)  index currently driving the mem_* signals

Behaviour:
- Request definition: port i requests when req_re[i] or |req_we[i].
- Requester protocol: hold all signals stable until req_ready[i].
- Arbiter response to a protocol violation: it keeps forwarding the owner's current signals until mem_ready.
- State IDLE:
  - Select a winner among requesting ports using the priority pointer.
  - Forward the winner's signals to mem_* combinationally in the same cycle.
  - If mem_ready is high that cycle, the transaction completes: req_ready[winner]=1 and the state stays IDLE.
  - Otherwise, register owner=winner and go to LOCKED.
- State LOCKED:
  - mem_* follow req_*[owner] only; new requests are ignored.
  - On mem_ready: req_ready[owner]=1, then return to IDLE.
  - Back-to-back transactions are allowed. The next arbitration happens in the cycle after completion, so there is no idle bubble beyond that cycle.
- Single-cycle throughput: with mem_ready tied high, one completion per cycle.
- Priority pointer (round_robin=1): on every completion, pointer = winner+1 mod ports. The completing port becomes lowest priority. Wrap: ports-1 → 0.
- Priority pointer (round_robin=0): constant 0.
- No request: mem_re=0, mem_we=0; mem_addr and mem_wdata are don't-care; grant_id holds its last value.
- req_ready[j]=0 for every non-owner port at all times. req_rdata = mem_rdata unmodified.
- Simultaneous requests from all ports: the winner is the first requesting index at or after the pointer, wrapping.
- A late requester never waits more than ports-1 transactions (starvation bound).
- Reset, while rst is high:
  - state=IDLE, pointer=0, owner=0, grant_id=0, busy=0.
  - mem_re=0, mem_we=0, and all req_ready=0, forced combinationally during reset.
- Reset mid-LOCKED: the transaction is abandoned. A mem_ready arriving during reset is ignored and not forwarded.
- Writes and reads are treated identically. A request with both re and we set is forwarded as-is; no priority between read and write.

Decomposition:
- Shared package boa_mem_pkg:
  - typedef boa_mem_req_t {re, we[3:0], addr[31:2], wdata[31:0]}
  - enum boa_arb_state_t {IDLE, LOCKED}
  - constant BOA_MEM_ARB_MAX_PORTS = 8
- Sub-module boa_rr_select: combinational rotating-priority encoder (request vector, pointer → one-hot grant plus index). Reused later for the interrupt priority selector.

Test Plan:
- Single request, zero-latency memory: port 0 req_re=1, addr=0x1000>>2, mem_ready tied 1, mem_rdata=0xDEADBEEF → same-cycle req_ready[0]=1, req_rdata=0xDEADBEEF, busy stays 0.
- Simultaneous requests from both ports: port 1 write we=0xF, wdata=0x12345678, mem_ready delayed 2 cycles → port 0 granted first; grant stays locked with busy=1 for 2 cycles; port 1 mem_we=0xF appears in the cycle after port 0's ready.
- Fairness: both ports requesting continuously, mem_ready=1 → grant_id sequence 0,1,0,1,… With round_robin=0 → 0,0,0,…
- Wrap at ports=3: all three requesting, 6 completions → grant order 0,1,2,0,1,2.
- Lock hold: port 0 is owner; port 1 raises a request mid-transaction and port 0 changes addr → mem_addr follows port 0, req_ready[1] stays 0 until port 0 completes.
- Reset mid-LOCKED: assert rst with owner=1 and mem_ready=1 in the same cycle → req_ready all 0 and mem_re/mem_we 0. After reset, a dual request grants port 0 first (pointer=0).
